hwpe_stream_merge_stride: RTL and testbench

- Inverse of the strided split: gathers NB_IN_STREAMS narrow HWPE-Stream inputs into one wide output stream.
- Re-interleaves elements: element jj of input ii lands at output element position ii + jj*NB_IN_STREAMS.
- Used on the load side, where TCDM-facing narrow streams return data at independent times and must be recombined into one wide vector for the datapath.
- Per-input holding registers and a registered output stage tolerate skew between inputs and break the timing path.

---
 rtl/hwpe_stream_merge_stride_if.sv | 13 +
 rtl/hwpe_stream_merge_stride.sv | 127 ++++++++++++
 tb/tb_hwpe_stream_merge_stride.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_merge_stride_if.sv
// HWPE-Stream handshake bundle: valid/ready with data and per-byte strobe.
// The master side drives valid/data/strb and the slave side drives ready.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 64
);
   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;

   modport master (output valid, output data, output strb, input ready);
   modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_merge_stride.sv
// Gathers NB_IN_STREAMS narrow streams into one wide stream; element jj of input ii lands at ii + jj*NB_IN_STREAMS.
// Optional 16-bit output beat counter (beat_cnt_o) when HWPE_STREAM_MERGE_STRIDE_CNT_EN is defined.
module hwpe_stream_merge_stride #(
   parameter int unsigned NB_IN_STREAMS = 4,
   parameter int unsigned DATA_WIDTH_IN = 64,
   parameter int unsigned ELEMENT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   hwpe_stream_intf_stream.slave  push_i [NB_IN_STREAMS],
   hwpe_stream_intf_stream.master pop_o
`ifdef HWPE_STREAM_MERGE_STRIDE_CNT_EN
   ,
   output logic [15:0]            beat_cnt_o
`endif
);
   localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN * NB_IN_STREAMS;
   localparam int unsigned NB_ELEM        = DATA_WIDTH_IN / ELEMENT_WIDTH;
   localparam int unsigned EB             = ELEMENT_WIDTH / 8;
   localparam int unsigned STRB_IN        = DATA_WIDTH_IN / 8;
   localparam int unsigned STRB_OUT       = DATA_WIDTH_OUT / 8;

   logic [NB_IN_STREAMS-1:0]  w_push_valid;
   logic [NB_IN_STREAMS-1:0]  w_push_ready;
   logic [NB_IN_STREAMS-1:0]  w_push_hs;
   logic [DATA_WIDTH_IN-1:0]  w_push_data [NB_IN_STREAMS];
   logic [STRB_IN-1:0]        w_push_strb [NB_IN_STREAMS];

   logic [NB_IN_STREAMS-1:0]  r_held;
   logic [DATA_WIDTH_IN-1:0]  r_data [NB_IN_STREAMS];
   logic [STRB_IN-1:0]        r_strb [NB_IN_STREAMS];

   logic                      r_out_valid;
   logic [DATA_WIDTH_OUT-1:0] r_out_data;
   logic [STRB_OUT-1:0]       r_out_strb;

   logic                      w_all_held;
   logic                      w_xfer;
   logic                      w_pop_hs;
   logic [DATA_WIDTH_OUT-1:0] w_merged_data;
   logic [STRB_OUT-1:0]       w_merged_strb;

   for (genvar gi = 0; gi < NB_IN_STREAMS; gi++) begin : g_in
      assign w_push_valid[gi] = push_i[gi].valid;
      assign w_push_data[gi]  = push_i[gi].data;
      assign w_push_strb[gi]  = push_i[gi].strb;
      assign push_i[gi].ready = w_push_ready[gi];
   end

   // A vector moves to the output only once every lane holds its part, so lanes never mix across vectors.
   assign w_all_held   = &r_held;
   assign w_xfer       = w_all_held & (~r_out_valid | pop_o.ready);
   assign w_push_ready = ~r_held | {NB_IN_STREAMS{w_xfer}};
   assign w_push_hs    = w_push_valid & w_push_ready;
   assign w_pop_hs     = r_out_valid & pop_o.ready;

   always_comb begin
      w_merged_data = '0;
      w_merged_strb = '0;
      for (int unsigned ii = 0; ii < NB_IN_STREAMS; ii++) begin
         for (int unsigned jj = 0; jj < NB_ELEM; jj++) begin
            w_merged_data[(ii + jj*NB_IN_STREAMS)*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
               r_data[ii][jj*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            w_merged_strb[(ii + jj*NB_IN_STREAMS)*EB +: EB] = r_strb[ii][jj*EB +: EB];
         end
      end
   end

   // A lane refilled in the same cycle its vector leaves stays held with the new word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_held <= '0;
      end else if (clear_i) begin
         r_held <= '0;
      end else begin
         r_held <= w_push_hs | (r_held & ~{NB_IN_STREAMS{w_xfer}});
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned ii = 0; ii < NB_IN_STREAMS; ii++) begin
         if (w_push_hs[ii]) begin
            r_data[ii] <= w_push_data[ii];
            r_strb[ii] <= w_push_strb[ii];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_strb  <= '0;
      end else if (clear_i) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_strb  <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_merged_data;
         r_out_strb  <= w_merged_strb;
      end else if (w_pop_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   assign pop_o.valid = r_out_valid;
   assign pop_o.data  = r_out_data;
   assign pop_o.strb  = r_out_strb;

`ifdef HWPE_STREAM_MERGE_STRIDE_CNT_EN
   logic [15:0] r_beat_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_beat_cnt <= '0;
      end else if (clear_i) begin
         r_beat_cnt <= '0;
      end else if (w_pop_hs) begin
         r_beat_cnt <= r_beat_cnt + 16'd1;
      end
   end

   assign beat_cnt_o = r_beat_cnt;
`endif
endmodule

// File: tb/tb_hwpe_stream_merge_stride.sv
// Bench for hwpe_stream_merge_stride: transaction-level reference model feeding a scoreboard,
// directed latency/skew/strobe/backpressure/streaming/clear scenarios plus a randomized phase.
`timescale 1ns/1ps
module tb_hwpe_stream_merge_stride;
   localparam int N   = 4;
   localparam int DW  = 64;
   localparam int EW  = 16;
   localparam int NE  = DW / EW;
   localparam int DWO = DW * N;
   localparam int SWO = DWO / 8;

   typedef struct packed {
      logic [7:0]    s;
      logic [DW-1:0] d;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic pop_ready;
   logic          tb_valid [N];
   logic [DW-1:0] tb_data  [N];
   logic [7:0]    tb_strb  [N];
   logic [DW-1:0] nxt_data [N];
   logic [7:0]    nxt_strb [N];
   logic [N-1:0]  w_ready;

   always #5 clk = ~clk;

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW))  push [N] ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DWO)) pop ();

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign push[g].valid = tb_valid[g];
      assign push[g].data  = tb_data[g];
      assign push[g].strb  = tb_strb[g];
      assign w_ready[g]    = push[g].ready;
   end
   assign pop.ready = pop_ready;

`ifdef HWPE_STREAM_MERGE_STRIDE_CNT_EN
   logic [15:0] beat_cnt;
`endif

   hwpe_stream_merge_stride #(
      .NB_IN_STREAMS (N),
      .DATA_WIDTH_IN (DW),
      .ELEMENT_WIDTH (EW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clear_i    (clear),
      .push_i     (push),
      .pop_o      (pop)
`ifdef HWPE_STREAM_MERGE_STRIDE_CNT_EN
      ,
      .beat_cnt_o (beat_cnt)
`endif
   );

   // Reference model: words accepted per lane, and complete wide vectors awaiting output.
   word_t q_in [N][$];
   logic [SWO+DWO-1:0] exp_q [$];

   int n_checks = 0;
   int n_err = 0;
   int cyc = 0;
   int beats = 0;
   int run = 0;
   int last_beat_cyc = -10;
   logic [15:0] cnt_model = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [SWO+DWO-1:0] act, input logic [SWO+DWO-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit have_vec();
      for (int i = 0; i < N; i++)
         if (q_in[i].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic build_vectors();
      logic [DWO-1:0] d;
      logic [SWO-1:0] s;
      word_t w;
      while (have_vec()) begin
         d = '0;
         s = '0;
         for (int ii = 0; ii < N; ii++) begin
            w = q_in[ii].pop_front();
            for (int jj = 0; jj < NE; jj++) begin
               d[(ii + jj*N)*EW +: EW] = w.d[jj*EW +: EW];
               s[(ii + jj*N)*2 +: 2]   = w.s[jj*2 +: 2];
            end
         end
         exp_q.push_back({s, d});
      end
   endtask

   // One clock cycle of stimulus; input handshakes are recorded just before the active edge.
   task automatic drive(input logic [N-1:0] v, input logic pr, input logic clr, output logic [N-1:0] hs);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         tb_valid[i] = v[i];
         tb_data[i]  = nxt_data[i];
         tb_strb[i]  = nxt_strb[i];
      end
      pop_ready = pr;
      clear     = clr;
      #1;
      hs = '0;
      if (clr) begin
         for (int i = 0; i < N; i++) q_in[i].delete();
         exp_q.delete();
      end else begin
         for (int i = 0; i < N; i++) begin
            if (tb_valid[i] && w_ready[i]) begin
               hs[i] = 1'b1;
               q_in[i].push_back({tb_strb[i], tb_data[i]});
            end
         end
         build_vectors();
      end
   endtask

   task automatic set_pattern(input int k);
      for (int ii = 0; ii < N; ii++) begin
         for (int jj = 0; jj < NE; jj++) nxt_data[ii][jj*EW +: EW] = 16'(k*256 + ii*16 + jj);
         nxt_strb[ii] = 8'hFF;
      end
   endtask

   task automatic set_random();
      for (int ii = 0; ii < N; ii++) begin
         nxt_data[ii] = {$urandom, $urandom};
         nxt_strb[ii] = 8'($urandom);
      end
   endtask

   // Monitor: compares every output handshake against the scoreboard and checks hold stability.
   logic [DWO-1:0] prev_data;
   logic [SWO-1:0] prev_strb;
   logic prev_stall = 1'b0;
   always @(negedge clk) begin
      #2;
      if (!rst_n || clear) begin
         prev_stall = 1'b0;
         cnt_model  = '0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", pop.valid, 1);
            chk("hold_data", {pop.strb, pop.data}, {prev_strb, prev_data});
         end
`ifdef HWPE_STREAM_MERGE_STRIDE_CNT_EN
         chk("beat_cnt", beat_cnt, cnt_model);
`endif
         if (pop.valid && pop.ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_beat: got %0h expected no beat", pop.data);
            end else begin
               chk("beat", {pop.strb, pop.data}, exp_q.pop_front());
            end
            beats++;
            run = (last_beat_cyc == cyc - 1) ? run + 1 : 1;
            last_beat_cyc = cyc;
            cnt_model = cnt_model + 16'd1;
         end
         prev_stall = pop.valid && !pop.ready;
         prev_data  = pop.data;
         prev_strb  = pop.strb;
      end
   end

   initial begin
      logic [N-1:0] hs;
      logic [DWO-1:0] od;
      logic [DWO-1:0] sdata;
      int acc;
      int full;
      int beats0;
      for (int i = 0; i < N; i++) begin
         tb_valid[i] = 1'b0;
         tb_data[i]  = '0;
         tb_strb[i]  = '0;
         nxt_data[i] = '0;
         nxt_strb[i] = '0;
      end
      pop_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_valid", pop.valid, 0);
      chk("rst_data", pop.data, 0);
      chk("rst_strb", pop.strb, 0);
      chk("rst_ready", w_ready, 4'hF);

      // Latency and element mapping.
      set_pattern(0);
      drive(4'hF, 1, 0, hs);
      chk("t1_hs", hs, 4'hF);
      drive(4'h0, 1, 0, hs);
      chk("t1_valid_c1", pop.valid, 0);
      drive(4'h0, 1, 0, hs);
      chk("t1_valid_c2", pop.valid, 1);
      od = pop.data;
      chk("t1_e0", od[0*EW +: EW], 16'h0000);
      chk("t1_e1", od[1*EW +: EW], 16'h0010);
      chk("t1_e4", od[4*EW +: EW], 16'h0001);
      chk("t1_e5", od[5*EW +: EW], 16'h0011);
      chk("t1_e15", od[15*EW +: EW], 16'h0033);
      chk("t1_strb", pop.strb, 32'hFFFF_FFFF);
      drive(4'h0, 1, 0, hs);

      // Skew: the early lanes wait for the slowest one.
      set_pattern(2);
      drive(4'b0011, 1, 0, hs);
      chk("t2_hs0", hs, 4'b0011);
      for (int c = 1; c <= 8; c++) begin
         drive((c == 3) ? 4'b0100 : (c == 7) ? 4'b1000 : 4'b0000, 1, 0, hs);
         if (c <= 7) chk("t2_ready0_low", w_ready[0], 0);
         chk("t2_no_early_valid", pop.valid, 0);
      end
      drive(4'h0, 1, 0, hs);
      chk("t2_valid_c9", pop.valid, 1);
      drive(4'h0, 1, 0, hs);

      // Partial strobe on one lane.
      set_pattern(3);
      nxt_strb[2] = 8'h0C;
      drive(4'hF, 1, 0, hs);
      drive(4'h0, 1, 0, hs);
      drive(4'h0, 1, 0, hs);
      chk("t3_strb", pop.strb, 32'hCFCF_FFCF);
      drive(4'h0, 1, 0, hs);

      // Backpressure: two vectors absorbed, then the inputs stall.
      acc = 0;
      set_pattern(10);
      for (int c = 0; c < 6; c++) begin
         drive(4'hF, 0, 0, hs);
         if (hs == 4'hF) begin
            acc++;
            set_pattern(10 + acc);
         end
         if (c == 2) sdata = pop.data;
      end
      chk("t4_accepted", acc, 2);
      chk("t4_ready_low", w_ready, 4'h0);
      chk("t4_data_stable", pop.data, sdata);
      drive(4'hF, 1, 0, hs);
      chk("t4_third_hs", hs, 4'hF);
      repeat (3) drive(4'h0, 1, 0, hs);
      chk("t4_consecutive", run, 3);

      // Randomized traffic with random backpressure, then drain and flush leftovers.
      for (int c = 0; c < 400; c++) begin
         set_random();
         drive(4'($urandom), ($urandom_range(0, 3) != 0), 0, hs);
      end
      repeat (5) drive(4'h0, 1, 0, hs);
      chk("rnd_drained", exp_q.size(), 0);
      drive(4'h0, 1, 1, hs);
      repeat (2) drive(4'h0, 1, 0, hs);
      chk("rnd_clear_ready", w_ready, 4'hF);

      // Full-rate streaming.
      full = 0;
      beats0 = beats;
      for (int c = 0; c < 100; c++) begin
         set_random();
         drive(4'hF, 1, 0, hs);
         if (hs == 4'hF) full++;
      end
      repeat (4) drive(4'h0, 1, 0, hs);
      chk("t5_accepted", full, 100);
      chk("t5_beats", beats - beats0, 100);
      chk("t5_consecutive", run, 100);
`ifdef HWPE_STREAM_MERGE_STRIDE_CNT_EN
      chk("t5_beat_cnt", beat_cnt, 100);
`endif

      // Clear wins over concurrent pop and push handshakes.
      set_pattern(20);
      drive(4'hF, 0, 0, hs);
      drive(4'h0, 0, 0, hs);
      set_pattern(21);
      drive(4'b0011, 0, 0, hs);
      chk("t6_pre_valid", pop.valid, 1);
      chk("t6_pre_held", hs, 4'b0011);
      set_pattern(22);
      drive(4'hF, 1, 1, hs);
      drive(4'h0, 1, 0, hs);
      chk("t6_valid", pop.valid, 0);
      chk("t6_ready", w_ready, 4'hF);
`ifdef HWPE_STREAM_MERGE_STRIDE_CNT_EN
      chk("t6_beat_cnt", beat_cnt, 0);
`endif
      for (int c = 0; c < 3; c++) begin
         drive(4'h0, 1, 0, hs);
         chk("t6_no_beat", pop.valid, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
